// File: rtl/computie_snoop_pkg.sv
// Shared definitions for the snoop dumper: record FSM state encoding, record
// byte counts, separator bytes and the nibble-to-ASCII helper.
// Optional feature macro: SNOOP_DUMP_ASCII_EN (ASCII hex record format).
package computie_snoop_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int RAW_REC_BYTES   = 8;
  localparam int ASCII_REC_BYTES = 19;

  localparam logic [7:0] SEP_SPACE = 8'h20;
  localparam logic [7:0] SEP_CR    = 8'h0D;
  localparam logic [7:0] SEP_LF    = 8'h0A;

  // Byte counter must reach 18 in the ASCII format.
  localparam int BCNT_W = 5;

  // Byte positions of the separators inside an ASCII record.
  localparam logic [BCNT_W-1:0] POS_SPACE = 5'd8;
  localparam logic [BCNT_W-1:0] POS_CR    = 5'd17;
  localparam logic [BCNT_W-1:0] POS_LF    = 5'd18;

`ifdef SNOOP_DUMP_ASCII_EN
  localparam int REC_BYTES = ASCII_REC_BYTES;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F' (upper case).
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction
`else
  localparam int REC_BYTES = RAW_REC_BYTES;
`endif

endpackage

// File: rtl/computie_snoop_byte_serializer.sv
// Turns one 64-bit {address, data} record into a byte stream with a
// valid/ready handshake. Raw build: 8 bytes, MSB first. With
// SNOOP_DUMP_ASCII_EN defined: 19 bytes "AAAAAAAA DDDDDDDD\r\n".
// Ports:
//   comm_clock, reset : clock, async active-high reset
//   clear             : zero the byte counter (start of a dump)
//   load, word        : capture a new record and restart at byte 0
//   active            : record FSM is offering bytes (drives valid)
//   ready             : transmitter accepts the current byte
//   data, valid       : byte stream out
//   last              : current byte is the final byte of the record
module computie_snoop_byte_serializer
  import computie_snoop_pkg::*;
(
  input  logic        comm_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [63:0] word,
  input  logic        active,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last
);

  logic [63:0]       shreg;
  logic [BCNT_W-1:0] cnt;
  logic [7:0]        cur_byte;
  logic              take;

  assign take  = active & ready;
  assign valid = active;
  assign last  = (cnt == BCNT_W'(REC_BYTES - 1));
  // Output is forced to zero outside SEND so reset/idle shows a clean bus.
  assign data  = active ? cur_byte : 8'h00;

`ifdef SNOOP_DUMP_ASCII_EN
  logic is_sep;

  // The top nibble of the shift register is always the next hex digit;
  // separator slots emit constants and leave the register untouched.
  always_comb begin
    is_sep   = 1'b1;
    cur_byte = 8'h00;
    case (cnt)
      POS_SPACE: cur_byte = SEP_SPACE;
      POS_CR:    cur_byte = SEP_CR;
      POS_LF:    cur_byte = SEP_LF;
      default: begin
        is_sep   = 1'b0;
        cur_byte = hex_ascii(shreg[63:60]);
      end
    endcase
  end
`else
  assign cur_byte = shreg[63:56];
`endif

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= word;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= last ? '0 : cnt + BCNT_W'(1);
`ifdef SNOOP_DUMP_ASCII_EN
      if (!is_sep) shreg <= {shreg[59:0], 4'h0};
`else
      shreg <= {shreg[55:0], 8'h00};
`endif
    end
  end

endmodule

// File: rtl/computie_snoop_dumper.sv
// Dumps the snoop capture buffer over a byte-wide UART handshake. Walks
// records 0..total-1, reading each through a one-cycle-latency buffer port
// and handing it to the byte serializer.
// Optional feature macro: SNOOP_DUMP_ASCII_EN (ASCII hex record format).
// Ports:
//   comm_clock, reset         : clock, async active-high reset
//   dump_start / dump_end     : level request / completion (held while requested)
//   record_count              : number of valid records, sampled at start
//   rec_index                 : buffer read address
//   rec_address, rec_data     : buffer read data, one cycle after rec_index
//   tx_data, tx_valid, tx_ready : byte stream to the UART transmitter
//
// state | meaning
// IDLE  | waiting for dump_start; latches the clamped record total
// FETCH | rec_index presented to the buffer
// LOAD  | buffer data valid; captured into the serializer
// SEND  | bytes of the current record offered to the transmitter
// NEXT  | advance rec_index; finish or fetch the next record
// DONE  | dump_end high until dump_start drops
//
// Only BITWIDTH = 32 is supported (records are packed into 64 bits).
module computie_snoop_dumper
  import computie_snoop_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 128
) (
  input  logic                     comm_clock,
  input  logic                     reset,
  input  logic                     dump_start,
  output logic                     dump_end,
  input  logic [$clog2(DEPTH):0]   record_count,
  output logic [$clog2(DEPTH)-1:0] rec_index,
  input  logic [BITWIDTH-1:0]      rec_address,
  input  logic [BITWIDTH-1:0]      rec_data,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  state_t        state, state_nx;
  logic [CW-1:0] total;
  logic [CW-1:0] count_clamped;
  logic [CW-1:0] index_plus1;
  logic          ser_last;
  logic          start_dump;

  assign count_clamped = (record_count > CW'(DEPTH)) ? CW'(DEPTH) : record_count;
  // Widened so the final index (DEPTH-1) + 1 can equal a total of DEPTH.
  assign index_plus1   = CW'(rec_index) + CW'(1);
  assign start_dump    = (state == IDLE) && dump_start;
  assign dump_end      = (state == DONE);

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      total     <= '0;
      rec_index <= '0;
    end else begin
      state <= state_nx;
      if (start_dump) begin
        total     <= count_clamped;
        rec_index <= '0;
      end else if (state == NEXT) begin
        rec_index <= rec_index + IW'(1);
      end
    end
  end

  // Dropping dump_start aborts at the next safe point: immediately outside
  // SEND, or once the byte currently offered has been accepted.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dump_start) state_nx = (count_clamped == '0) ? DONE : FETCH;
      end
      FETCH: state_nx = dump_start ? LOAD : IDLE;
      LOAD:  state_nx = dump_start ? SEND : IDLE;
      SEND: begin
        if (tx_ready) begin
          if (!dump_start)   state_nx = IDLE;
          else if (ser_last) state_nx = NEXT;
        end
      end
      NEXT: begin
        if (!dump_start)             state_nx = IDLE;
        else if (index_plus1 == total) state_nx = DONE;
        else                         state_nx = FETCH;
      end
      DONE: begin
        if (!dump_start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  computie_snoop_byte_serializer u_serializer (
    .comm_clock (comm_clock),
    .reset      (reset),
    .clear      (start_dump),
    .load       (state == LOAD),
    .word       ({rec_address, rec_data}),
    .active     (state == SEND),
    .ready      (tx_ready),
    .data       (tx_data),
    .valid      (tx_valid),
    .last       (ser_last)
  );

endmodule

// File: tb/tb_computie_snoop_dumper.sv
module tb_computie_snoop_dumper;

  localparam int DEPTH = 128;
  localparam int IW    = 7;
  localparam int CW    = IW + 1;
`ifdef SNOOP_DUMP_ASCII_EN
  localparam int BPR = 19;
`else
  localparam int BPR = 8;
`endif

  logic          comm_clock = 1'b0;
  logic          reset      = 1'b1;
  logic          dump_start = 1'b0;
  logic          tx_ready   = 1'b0;
  logic [CW-1:0] record_count = '0;
  logic          dump_end, tx_valid;
  logic [IW-1:0] rec_index;
  logic [31:0]   rec_address, rec_data;
  logic [7:0]    tx_data;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         got_cyc[$];
  int cyc = 0, stall_errs = 0, valid_seen = 0, max_idx = 0;
  int vectors = 0, miscompares = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 comm_clock = ~comm_clock;

  computie_snoop_dumper #(.BITWIDTH(32), .DEPTH(DEPTH)) dut (
    .comm_clock   (comm_clock),
    .reset        (reset),
    .dump_start   (dump_start),
    .dump_end     (dump_end),
    .record_count (record_count),
    .rec_index    (rec_index),
    .rec_address  (rec_address),
    .rec_data     (rec_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  // Capture buffer: synchronous read, one cycle of latency.
  always @(posedge comm_clock) begin
    rec_address <= mem_a[rec_index];
    rec_data    <= mem_d[rec_index];
    cyc         <= cyc + 1;
  end

  // Byte monitor, sampled mid-cycle.
  always @(negedge comm_clock) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
    if (prev_stall && tx_valid === 1'b1 && tx_data !== prev_data) stall_errs++;
    prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
    prev_data  = tx_data;
    if (tx_valid === 1'b1) valid_seen++;
    if (int'(rec_index) > max_idx) max_idx = int'(rec_index);
  end

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference byte stream for records 0..n-1.
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
`ifdef SNOOP_DUMP_ASCII_EN
      for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(int'((mem_a[r] >> (4 * k)) & 32'hF)));
      exp_q.push_back(8'h20);
      for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(int'((mem_d[r] >> (4 * k)) & 32'hF)));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`else
      for (int k = 3; k >= 0; k--) exp_q.push_back(8'((mem_a[r] >> (8 * k)) & 32'hFF));
      for (int k = 3; k >= 0; k--) exp_q.push_back(8'((mem_d[r] >> (8 * k)) & 32'hFF));
`endif
    end
  endtask

  // mode 0: ready always high, 1: toggling, 2: random (~75% high)
  task automatic run_dump(input int cnt, input int mode, input int max_cycles, output bit timed_out);
    got.delete(); got_cyc.delete();
    stall_errs = 0; valid_seen = 0; max_idx = 0;
    record_count = CW'(cnt);
    dump_start = 1'b1;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = c[0];
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge comm_clock); #1;
      if (dump_end === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    dump_start = 1'b0;
    tx_ready = 1'b0;
    @(posedge comm_clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (dump_end !== 1'b0) begin miscompares++; $display("FAIL reset dump_end: got %b expected 0", dump_end); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset tx_data: got %02h expected 00", tx_data); end
    vectors++; if (rec_index !== '0) begin miscompares++; $display("FAIL reset rec_index: got %0d expected 0", rec_index); end
    repeat (3) @(posedge comm_clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge comm_clock);
    #1;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL post-reset tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (dump_end !== 1'b0) begin miscompares++; $display("FAIL post-reset dump_end: got %b expected 0", dump_end); end
  endtask

  task automatic test_directed();
    bit to;
    logic [7:0] lit[$];
`ifdef SNOOP_DUMP_ASCII_EN
    string s;
    s = "00FF1234 DEADBEEF";
    for (int i = 0; i < s.len(); i++) lit.push_back(s[i]);
    lit.push_back(8'h0D);
    lit.push_back(8'h0A);
`else
    logic [63:0] w;
    w = 64'h00FF1234_DEADBEEF;
    for (int k = 0; k < 8; k++) lit.push_back(w[63 - 8 * k -: 8]);
`endif
    mem_a[0] = 32'h00FF1234;
    mem_d[0] = 32'hDEADBEEF;
    run_dump(1, 0, 200, to);
    vectors++; if (to) begin miscompares++; $display("FAIL directed dump_end: got 0 expected 1 within 200 cycles"); end
    vectors++; if (got.size() != lit.size()) begin miscompares++; $display("FAIL directed count: got %0d expected %0d", got.size(), lit.size()); end
    for (int i = 0; i < lit.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== lit[i]) begin miscompares++; $display("FAIL directed byte %0d: got %02h expected %02h", i, got[i], lit[i]); end
    end
  endtask

  task automatic test_zero_count();
    bit seen;
    valid_seen = 0;
    seen = 1'b0;
    record_count = '0;
    dump_start = 1'b1;
    tx_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge comm_clock); #1;
      if (dump_end === 1'b1) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL zero dump_end: got %b expected 1 within 2 cycles", dump_end); end
    repeat (3) @(posedge comm_clock);
    #1;
    vectors++; if (dump_end !== 1'b1) begin miscompares++; $display("FAIL zero dump_end held: got %b expected 1", dump_end); end
    vectors++; if (valid_seen != 0) begin miscompares++; $display("FAIL zero tx_valid cycles: got %0d expected 0", valid_seen); end
    dump_start = 1'b0;
    tx_ready = 1'b0;
    @(posedge comm_clock); #1;
    vectors++; if (dump_end !== 1'b0) begin miscompares++; $display("FAIL zero dump_end clear: got %b expected 0", dump_end); end
  endtask

  task automatic test_stall();
    bit to;
    build_exp(3);
    run_dump(3, 1, 400, to);
    vectors++; if (to) begin miscompares++; $display("FAIL stall dump_end: got 0 expected 1 within 400 cycles"); end
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL stall count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall byte %0d: got %02h expected %02h", i, got[i], exp_q[i]); end
    end
    vectors++; if (stall_errs != 0) begin miscompares++; $display("FAIL stall stability: got %0d changes expected 0", stall_errs); end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 6);
      build_exp(n);
      run_dump(n, 2, 2000, to);
      vectors++; if (to) begin miscompares++; $display("FAIL random[%0d] dump_end: got 0 expected 1", it); end
      vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL random[%0d] count: got %0d expected %0d", it, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin miscompares++; $display("FAIL random[%0d] byte %0d: got %02h expected %02h", it, i, got[i], exp_q[i]); end
      end
      vectors++; if (stall_errs != 0) begin miscompares++; $display("FAIL random[%0d] stability: got %0d changes expected 0", it, stall_errs); end
    end
  endtask

  task automatic test_throughput();
    bit to;
    int rel, want;
    build_exp(4);
    run_dump(4, 0, 400, to);
    vectors++; if (to) begin miscompares++; $display("FAIL throughput dump_end: got 0 expected 1"); end
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL throughput count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int j = 0; j < got_cyc.size() && j < exp_q.size(); j++) begin
      rel  = got_cyc[j] - got_cyc[0];
      want = (j / BPR) * (BPR + 3) + (j % BPR);
      vectors++;
      if (rel != want) begin miscompares++; $display("FAIL throughput byte %0d cycle: got %0d expected %0d", j, rel, want); end
    end
  endtask

  task automatic test_clamp();
    bit to;
    build_exp(DEPTH);
    run_dump(200, 0, 6000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL clamp dump_end: got 0 expected 1"); end
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL clamp count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin miscompares++; $display("FAIL clamp byte %0d: got %02h expected %02h", i, got[i], exp_q[i]); end
    end
    vectors++; if (max_idx > DEPTH - 1) begin miscompares++; $display("FAIL clamp rec_index max: got %0d expected <= %0d", max_idx, DEPTH - 1); end
  endtask

  task automatic test_abort();
    bit reached;
    build_exp(3);
    got.delete(); got_cyc.delete(); stall_errs = 0;
    record_count = CW'(3);
    dump_start = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      @(posedge comm_clock); #1;
      if (got.size() >= 5) begin reached = 1'b1; break; end
    end
    vectors++; if (!reached) begin miscompares++; $display("FAIL abort reach: got %0d bytes expected 5", got.size()); end
    dump_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tx_ready = ($urandom_range(0, 1) != 0);
      @(posedge comm_clock); #1;
    end
    tx_ready = 1'b0;
    vectors++; if (got.size() != 6) begin miscompares++; $display("FAIL abort count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort byte %0d: got %02h expected %02h", i, got[i], exp_q[i]); end
    end
    vectors++; if (dump_end !== 1'b0) begin miscompares++; $display("FAIL abort dump_end: got %b expected 0", dump_end); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL abort tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (stall_errs != 0) begin miscompares++; $display("FAIL abort stability: got %0d changes expected 0", stall_errs); end
  endtask

  task automatic test_reset_mid();
    bit reached, to;
    got.delete(); got_cyc.delete();
    record_count = CW'(2);
    dump_start = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      @(posedge comm_clock); #1;
      if (got.size() >= 5) begin reached = 1'b1; break; end
    end
    vectors++; if (!reached) begin miscompares++; $display("FAIL rstmid reach: got %0d bytes expected 5", got.size()); end
    reset = 1'b1;
    #1;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (dump_end !== 1'b0) begin miscompares++; $display("FAIL rstmid dump_end: got %b expected 0", dump_end); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid tx_data: got %02h expected 00", tx_data); end
    vectors++; if (rec_index !== '0) begin miscompares++; $display("FAIL rstmid rec_index: got %0d expected 0", rec_index); end
    dump_start = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge comm_clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge comm_clock);
    #1;
    vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL rstmid resumed: got %0d bytes expected 5", got.size()); end
    // A fresh dump afterwards starts from record 0, byte 0.
    build_exp(1);
    run_dump(1, 0, 200, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rstmid redump dump_end: got 0 expected 1"); end
    vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid redump count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid redump byte %0d: got %02h expected %02h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = $urandom;
      mem_d[i] = $urandom;
    end
    test_reset();
    test_directed();
    test_zero_count();
    test_stall();
    test_random();
    test_throughput();
    test_clamp();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/computie_snoop_dumper.md
COMPUTIE_SNOOP_DUMPER -- requirements
Module: computie_snoop_dumper

Interface
REQ-001 Parameter BITWIDTH, default 32, SHALL set the width of each captured address and data word; only 32 is supported.
REQ-002 Parameter DEPTH, default 128, SHALL set the number of record slots in the capture buffer.
REQ-003 comm_clock  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 dump_start  input  1  SHALL be the level request to dump.
REQ-006 dump_end  output  1  SHALL mean the dump is complete; it is held while dump_start stays high.
REQ-007 record_count  input  $clog2(DEPTH)+1  SHALL give the number of valid records, sampled at dump start.
REQ-008 rec_index  output  $clog2(DEPTH)  SHALL be the read address into the capture buffer.
REQ-009 rec_address  input  BITWIDTH  SHALL be the captured address at rec_index, valid one cycle after rec_index changes.
REQ-010 rec_data  input  BITWIDTH  SHALL be the captured data at rec_index, with the same one-cycle latency.
REQ-011 tx_data  output  8  SHALL be the byte offered to the UART transmitter.
REQ-012 tx_valid  output  1  SHALL mean tx_data is valid.
REQ-013 tx_ready  input  1  SHALL mean the transmitter accepts the byte; a transfer occurs on a cycle where tx_valid and tx_ready are both high.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, LOAD, SEND, NEXT and DONE.
REQ-015 In IDLE, dump_start high SHALL latch record_count into a total register, clear rec_index and the byte counter, and move to FETCH.
REQ-016 If the latched total is 0, IDLE SHALL move directly to DONE and emit no bytes.
REQ-017 FETCH SHALL present rec_index for one cycle, then move to LOAD.
REQ-018 LOAD SHALL capture {rec_address, rec_data} into a 64-bit shift register and move to SEND.
REQ-019 Per record, SEND SHALL emit the address MSB-first (4 bytes), then the data MSB-first (4 bytes).
REQ-020 tx_valid SHALL be high only in SEND.
REQ-021 tx_data SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-022 After the last byte of a record transfers, the FSM SHALL enter NEXT, which increments rec_index.
REQ-023 NEXT SHALL go to DONE if rec_index+1 equals the total, otherwise to FETCH.
REQ-024 DONE SHALL hold dump_end high and tx_valid low, and return to IDLE when dump_start is low.
REQ-025 A total greater than DEPTH SHALL be clamped to DEPTH.
REQ-026 If dump_start falls mid-dump, the byte in flight SHALL complete its handshake, then the FSM SHALL go to IDLE without asserting dump_end.
REQ-027 With tx_ready held high, throughput SHALL be one byte per cycle within a record plus 3 overhead cycles per record (NEXT, FETCH, LOAD).

Reset
REQ-028 Reset SHALL force IDLE and clear tx_valid, dump_end, tx_data, rec_index, the byte counter and the total.
REQ-029 Reset asserted mid-transfer SHALL drop tx_valid immediately; no partial record is resumed.

Configuration
REQ-030 With SNOOP_DUMP_ASCII_EN defined, each record SHALL be emitted as 19 ASCII bytes: 8 upper-case hex digits of the address, 0x20, 8 hex digits of the data, 0x0D, 0x0A.
REQ-031 With SNOOP_DUMP_ASCII_EN defined, the nibble-to-ASCII mapping SHALL be 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46.
REQ-032 Without SNOOP_DUMP_ASCII_EN, each record SHALL be emitted as 8 raw binary bytes, and no ASCII logic is synthesized.

Structure
REQ-033 A shared package computie_snoop_pkg SHALL hold the FSM state encoding, the record byte counts (8 and 19) and the separator constants (0x20, 0x0D, 0x0A).
REQ-034 Byte sequencing SHALL be implemented in sub-module computie_snoop_byte_serializer, which takes a 64-bit word and produces the byte stream with valid/ready handshake; the ASCII formatting lives inside it under the macro.
REQ-035 The top module SHALL contain only the record FSM and the buffer read port.

Verification
REQ-036 Raw mode, count=1, record {0x00FF1234, 0xDEADBEEF}, tx_ready=1 -> bytes 00 FF 12 34 DE AD BE EF, then dump_end=1.
REQ-037 ASCII mode, same record -> "00FF1234 DEADBEEF\r\n" (19 bytes), then dump_end=1.
REQ-038 count=0, dump_start=1 -> no tx_valid; dump_end=1 within 2 cycles; dump_end clears 1 cycle after dump_start falls.
REQ-039 count=3, tx_ready toggling every other cycle -> 24 bytes in record order 0,1,2; tx_data stable whenever stalled.
REQ-040 count=200 with DEPTH=128 -> exactly 128 records emitted; rec_index never exceeds 127.
REQ-041 dump_start dropped after byte 5, and separately reset asserted after byte 5 -> first case: byte 6 completes, then IDLE with dump_end=0; second case: tx_valid=0 immediately and all outputs at reset values.
